// File: rtl/cmd_initiator_if.sv
// Signal bundle for cmd_initiator: command input, 8-bit command stream out,
// 32-bit tkeep/tlast response stream in, and the per-transaction response summary.
interface cmd_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [63:0] cmd_data;

    logic        m_tvalid;
    logic        m_tready;
    logic [7:0]  m_tdata;

    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tlast;

    logic        word_valid;
    logic [31:0] word_data;
    logic        rsp_valid;
    logic [31:0] rsp_first;
    logic [15:0] rsp_bytes;
    logic        rsp_timeout;
    logic        busy;

    modport master (
        input  cmd_valid, cmd_data, m_tready,
        input  s_tvalid, s_tdata, s_tkeep, s_tlast,
        output cmd_ready, m_tvalid, m_tdata, s_tready,
        output word_valid, word_data, rsp_valid, rsp_first, rsp_bytes, rsp_timeout, busy
    );

    modport slave (
        output cmd_valid, cmd_data, m_tready,
        output s_tvalid, s_tdata, s_tkeep, s_tlast,
        input  cmd_ready, m_tvalid, m_tdata, s_tready,
        input  word_valid, word_data, rsp_valid, rsp_first, rsp_bytes, rsp_timeout, busy
    );
endinterface

// File: rtl/cmd_initiator.sv
// Host-side command initiator: serialises a 64-bit command LSB-byte-first onto an
// 8-bit stream, then collects the framed 32-bit response with an idle timeout.
module cmd_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic            clk,
    input  logic            rst,
    cmd_initiator_if.master bus
);
    localparam int unsigned      CNT_W           = 20;
    localparam logic [CNT_W-1:0] IDLE_LAST       = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       LAST_RSP_OPCODE = 8'd5;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        RESP,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [63:0]      cmd_q;
    logic [2:0]       idx_q;
    logic [CNT_W-1:0] idle_cnt_q;
    logic             first_seen_q;
    logic             word_valid_q;
    logic [31:0]      word_data_q;
    logic [31:0]      rsp_first_q;
    logic [15:0]      rsp_bytes_q;
    logic             rsp_timeout_q;

    logic cmd_fire;
    logic byte_fire;
    logic beat_fire;
    logic tmo_hit;

    // Keep is contiguous from bit 0, but a plain popcount is cheap and tolerates anything.
    function automatic logic [2:0] keep_bytes(input logic [3:0] keep);
        keep_bytes = 3'(keep[0]) + 3'(keep[1]) + 3'(keep[2]) + 3'(keep[3]);
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] acc, input logic [2:0] inc);
        logic [16:0] sum;
        sum       = {1'b0, acc} + 17'(inc);
        sat_add16 = sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.cmd_ready = 1'b0;
        bus.m_tvalid  = 1'b0;
        bus.m_tdata   = 8'h00;
        bus.s_tready  = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.busy      = 1'b1;
        cmd_fire      = 1'b0;
        byte_fire     = 1'b0;
        beat_fire     = 1'b0;
        tmo_hit       = 1'b0;

        case (state_q)
            IDLE: begin
                bus.busy      = 1'b0;
                bus.cmd_ready = !rst;
                if (bus.cmd_valid && !rst) begin
                    cmd_fire = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                bus.m_tvalid = 1'b1;
                bus.m_tdata  = cmd_q[{idx_q, 3'b000} +: 8];
                if (bus.m_tready) begin
                    byte_fire = 1'b1;
                    if (idx_q == 3'd7) begin
                        // Opcodes above 5 have no reply, so skip straight to completion.
                        state_d = (cmd_q[7:0] <= LAST_RSP_OPCODE) ? RESP : DONE;
                    end
                end
            end
            RESP: begin
                bus.s_tready = 1'b1;
                if (bus.s_tvalid) begin
                    beat_fire = 1'b1;
                    if (bus.s_tlast) begin
                        state_d = DONE;
                    end
                end else if (idle_cnt_q == IDLE_LAST) begin
                    tmo_hit = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.rsp_valid = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q         <= '0;
            idx_q         <= '0;
            idle_cnt_q    <= '0;
            first_seen_q  <= 1'b0;
            word_valid_q  <= 1'b0;
            word_data_q   <= '0;
            rsp_first_q   <= '0;
            rsp_bytes_q   <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;

            if (cmd_fire) begin
                cmd_q         <= bus.cmd_data;
                idx_q         <= '0;
                first_seen_q  <= 1'b0;
                rsp_first_q   <= '0;
                rsp_bytes_q   <= '0;
                rsp_timeout_q <= 1'b0;
            end

            if (byte_fire) begin
                idx_q <= idx_q + 3'd1;
            end

            // Idle counter runs only in RESP and restarts on every accepted beat.
            if (cmd_fire) begin
                idle_cnt_q <= '0;
            end else if (state_q == RESP) begin
                if (beat_fire) begin
                    idle_cnt_q <= '0;
                end else begin
                    idle_cnt_q <= idle_cnt_q + CNT_W'(1);
                end
            end

            if (beat_fire) begin
                rsp_bytes_q <= sat_add16(rsp_bytes_q, keep_bytes(bus.s_tkeep));
                if (bus.s_tkeep != 4'b0000) begin
                    word_valid_q <= 1'b1;
                    word_data_q  <= bus.s_tdata;
                    if (!first_seen_q) begin
                        rsp_first_q  <= bus.s_tdata;
                        first_seen_q <= 1'b1;
                    end
                end
            end

            if (tmo_hit) begin
                rsp_timeout_q <= 1'b1;
            end
        end
    end

    assign bus.word_valid  = word_valid_q;
    assign bus.word_data   = word_data_q;
    assign bus.rsp_first   = rsp_first_q;
    assign bus.rsp_bytes   = rsp_bytes_q;
    assign bus.rsp_timeout = rsp_timeout_q;

endmodule
